// File: rtl/gh_pkg.sv
// gh_pkg: shared constants, lane state and BCD types for the note hit scorer.
package gh_pkg;
  localparam int LANES = 4;
  localparam int STREAK_STEP = 10;
  localparam int MULT_MAX = 4;
  localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;
  typedef enum logic {IDLE, ARMED} lane_state_t;
  typedef logic [3:0] bcd_digit_t;
  function automatic logic [2:0] calc_mult(input logic [7:0] streak);
    logic [7:0] q;
    q = streak / 8'(STREAK_STEP);
    return (q >= 8'(MULT_MAX - 1)) ? 3'(MULT_MAX) : 3'(q + 8'd1);
  endfunction
endpackage

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: 4-digit BCD up-counter that saturates at 9999.
module bcd_score_counter
  import gh_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] bcd,
  output logic        at_max
);
  bcd_digit_t [3:0] r_dig, w_next;
  logic w_c;
  assign bcd = r_dig;
  assign at_max = (r_dig == SCORE_MAX_BCD);
  always_comb begin
    w_c = inc & ~at_max;
    for (int k = 0; k < 4; k++) begin
      w_next[k] = w_c ? ((r_dig[k] == 4'd9) ? 4'd0 : r_dig[k] + 4'd1) : r_dig[k];
      w_c = w_c & (r_dig[k] == 4'd9);
    end
  end
  always_ff @(posedge clk)
    r_dig <= clear ? '0 : w_next;
endmodule

// File: rtl/note_hit_scorer.sv
// note_hit_scorer: judges presses against note windows per lane, tracks streak and
// multiplier, and drains earned credits as one-cycle point pulses into a BCD score.
module note_hit_scorer
  import gh_pkg::*;
#(
  parameter int HIT_WINDOW = 5_000_000
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [LANES-1:0] note_arrive,
  input  logic [LANES-1:0] btn,
  output logic             points,
  output logic [15:0]      score_bcd,
  output logic [7:0]       streak,
  output logic [2:0]       mult,
  output logic [LANES-1:0] hit,
  output logic [LANES-1:0] miss
);
  localparam int CW = $clog2(HIT_WINDOW + 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(HIT_WINDOW - 1);
  logic [LANES-1:0] r_btn_prev, r_hit, r_miss, w_press, w_hit, w_miss, w_wrong;
  logic [7:0] r_credits, r_streak;
  logic [2:0] w_n;
  logic [9:0] w_add, w_sum;
  logic [8:0] w_streak_sum;
  logic r_points, w_at_max, w_drain;
  assign w_press = btn & ~r_btn_prev;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_state_t r_state;
    logic [CW-1:0] r_cnt;
    assign w_hit[i] = w_press[i] & (note_arrive[i] | (r_state == ARMED));
    assign w_miss[i] = (r_state == ARMED) & ~w_press[i] & (note_arrive[i] | (r_cnt == '0));
    assign w_wrong[i] = w_press[i] & ~note_arrive[i] & (r_state == IDLE);
    // A new note while armed always restarts the window, whether the old one hit or missed.
    always_ff @(posedge clk)
      if (clear) begin
        r_state <= IDLE;
        r_cnt <= '0;
      end else if (r_state == IDLE) begin
        if (note_arrive[i] & ~w_press[i]) begin
          r_state <= ARMED;
          r_cnt <= WIN_LAST;
        end
      end else if (note_arrive[i]) r_cnt <= WIN_LAST;
      else if (w_press[i] | (r_cnt == '0)) r_state <= IDLE;
      else r_cnt <= r_cnt - 1'b1;
  end
  assign mult = calc_mult(r_streak);
  assign w_n = 3'($countones(w_hit));
  assign w_add = 10'(w_n) * 10'(mult);
  assign w_drain = (r_credits != 8'd0) & ~w_at_max;
  assign w_sum = 10'(r_credits) + w_add - 10'(w_drain);
  assign w_streak_sum = 9'(r_streak) + 9'(w_n);
  always_ff @(posedge clk) begin
    r_btn_prev <= btn;
    if (clear) begin
      r_hit <= '0;
      r_miss <= '0;
      r_points <= 1'b0;
      r_credits <= '0;
      r_streak <= '0;
    end else begin
      r_hit <= w_hit;
      r_miss <= w_miss;
      r_points <= w_drain;
      // Once the score is pinned at 9999, leftover credits are dropped so the display never overshoots.
      r_credits <= w_at_max ? 8'd0 : (w_sum > 10'd255 ? 8'hFF : w_sum[7:0]);
      r_streak <= (|w_miss | |w_wrong) ? 8'd0 : (w_streak_sum > 9'd255 ? 8'hFF : w_streak_sum[7:0]);
    end
  end
  bcd_score_counter u_score (
    .clk(clk),
    .clear(clear),
    .inc(w_drain),
    .bcd(score_bcd),
    .at_max(w_at_max)
  );
  assign points = r_points;
  assign streak = r_streak;
  assign hit = r_hit;
  assign miss = r_miss;
endmodule
